// File: rtl/router_ingress.sv
// rtl/router_ingress.sv - 1x3 router input stage: header parse, FIFO routing, parity check
module router_ingress #(
    parameter int DW     = 8,
    parameter bit PAR_WR = 1'b1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [DW-1:0] data_in,
    input  logic          pkt_vld,
    input  logic [2:0]    fifo_full,
    output logic          busy,
    output logic          error,
    output logic [DW-1:0] dout,
    output logic [2:0]    wr_en,
    output logic          pkt_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_DROP   = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    r_dest;
    logic [5:0]    r_count;
    logic [DW-1:0] r_par;
    logic          r_error;
    logic          r_pkt_done;

    logic          w_busy;
    logic          w_acc;
    logic          w_wr_ok;
    logic [1:0]    w_sel;
    logic [3:0]    w_full4;

    // Destination 3 never has a FIFO, so its full flag reads as 0.
    assign w_full4 = {1'b0, fifo_full};

    always_comb begin
        w_busy  = 1'b0;
        w_sel   = r_dest;
        w_wr_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel   = data_in[1:0];
                w_busy  = pkt_vld & w_full4[data_in[1:0]];
                w_wr_ok = (data_in[1:0] != 2'd3);
            end
            S_DATA: begin
                w_busy  = w_full4[r_dest];
                w_wr_ok = 1'b1;
            end
            S_PARITY: begin
                w_busy  = w_full4[r_dest];
                w_wr_ok = PAR_WR;
            end
            default: ;
        endcase
    end

    assign w_acc    = pkt_vld & ~w_busy;
    assign busy     = w_busy;
    assign dout     = data_in;
    assign wr_en    = (w_acc & w_wr_ok) ? (3'b001 << w_sel) : 3'b000;
    assign error    = r_error;
    assign pkt_done = r_pkt_done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_dest     <= 2'd0;
            r_count    <= 6'd0;
            r_par      <= '0;
            r_error    <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        r_dest  <= data_in[1:0];
                        r_count <= data_in[7:2];
                        r_par   <= data_in;
                        r_error <= 1'b0;
                        if (data_in[1:0] == 2'd3)
                            r_state <= S_DROP;
                        else if (data_in[7:2] != 6'd0)
                            r_state <= S_DATA;
                        else
                            r_state <= S_PARITY;
                    end
                    S_DATA: begin
                        r_par   <= r_par ^ data_in;
                        r_count <= r_count - 6'd1;
                        if (r_count == 6'd1)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_error    <= (data_in != r_par);
                        r_pkt_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        // Dropped packet: burn the payload, flag the error on its parity byte.
                        if (r_count != 6'd0) begin
                            r_count <= r_count - 6'd1;
                        end else begin
                            r_error    <= 1'b1;
                            r_pkt_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
